// File: rtl/kgp_pc_pkg.sv
// Shared constants and next-PC select encoding for the KGP-RISC program-counter unit.
package kgp_pc_pkg;

    localparam int unsigned PC_W_DEF      = 32;
    localparam int unsigned INC_DEF       = 4;
    localparam logic [31:0] RESET_VEC_DEF = '0;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_RET,
        SEL_CALL,
        SEL_BR,
        SEL_SEQ
    } pc_sel_e;

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: a push while full overwrites the oldest entry.
// Sticky overflow/underflow flags clear only on reset.
module ras_stack #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [W-1:0]               i_push_data,
    output logic [W-1:0]               o_top,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_empty,
    output logic                       o_overflow,
    output logic                       o_underflow
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;
    logic          w_full;

    assign w_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_top       = r_mem[r_ptr - PW'(1)];
    assign o_count     = r_count;
    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;

    // Entry contents are don't-care after reset, so storage carries no reset.
    always_ff @(posedge clk) begin
        if (i_push && !rst) begin
            r_mem[r_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (i_push) begin
            r_ptr <= r_ptr + PW'(1);
            if (w_full) begin
                r_overflow <= 1'b1;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end else if (i_pop) begin
            if (o_empty) begin
                r_underflow <= 1'b1;
            end else begin
                r_ptr   <= r_ptr - PW'(1);
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program-counter unit with priority next-PC select and embedded return-address stack.
// Optional macro PC_ALIGN_CHECK_EN adds a sticky misalign output and rejects unaligned redirects.
module pc_unit
    import kgp_pc_pkg::*;
#(
    parameter int unsigned     PC_W      = PC_W_DEF,
    parameter int unsigned     INC       = INC_DEF,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(RESET_VEC_DEF),
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           br_taken,
    input  logic [PC_W-1:0]                br_target,
    input  logic                           call,
    input  logic                           ret,
    output logic [PC_W-1:0]                pc_out,
    output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
    output logic                           ras_overflow,
    output logic                           ras_underflow
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic                           misalign
`endif
);
    localparam logic [PC_W-1:0] INC_V = PC_W'(INC);

    logic [PC_W-1:0] r_pc;
    pc_sel_e         w_sel;
    logic [PC_W-1:0] w_seq;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_next;
    logic [PC_W-1:0] w_ras_top;
    logic            w_ras_empty;
    logic            w_bad;
    logic            w_push;
    logic            w_pop;

    always_comb begin
        w_sel = SEL_SEQ;
        if (stall)         w_sel = SEL_HOLD;
        else if (ret)      w_sel = SEL_RET;
        else if (call)     w_sel = SEL_CALL;
        else if (br_taken) w_sel = SEL_BR;
    end

    always_comb begin
        w_seq    = r_pc + INC_V;
        w_target = (w_sel == SEL_RET) ? w_ras_top : br_target;
        w_bad    = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        // An empty-stack ret has no target to validate; it takes the underflow path.
        w_bad = ((w_sel == SEL_CALL) || (w_sel == SEL_BR) ||
                 ((w_sel == SEL_RET) && !w_ras_empty)) &&
                ((w_target % INC_V) != '0);
`endif
        w_next = w_seq;
        unique case (w_sel)
            SEL_HOLD:         w_next = r_pc;
            SEL_RET:          if (!w_ras_empty && !w_bad) w_next = w_target;
            SEL_CALL, SEL_BR: if (!w_bad) w_next = w_target;
            default:          w_next = w_seq;
        endcase
    end

    // A rejected call leaves the stack alone; a rejected ret still consumes its pop.
    assign w_push = (w_sel == SEL_CALL) && !w_bad;
    assign w_pop  = (w_sel == SEL_RET);

    always_ff @(posedge clk) begin
        if (rst) r_pc <= RESET_VEC;
        else     r_pc <= w_next;
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign;
    always_ff @(posedge clk) begin
        if (rst)        r_misalign <= 1'b0;
        else if (w_bad) r_misalign <= 1'b1;
    end
    assign misalign = r_misalign;
`endif

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_seq),
        .o_top       (w_ras_top),
        .o_count     (ras_count),
        .o_empty     (w_ras_empty),
        .o_overflow  (ras_overflow),
        .o_underflow (ras_underflow)
    );

    assign pc_out = r_pc;

endmodule
